block_unpad_words: RTL and testbench

Decrypt-side output adapter for the AES datapath. It accepts 128-bit plaintext blocks and emits 32-bit words with byte-keep and last markers. On the final block of a message it strips PKCS#7 padding and emits only the payload bytes. It sits between the AES core output and the 32-bit result FIFO, and is the receive-side counterpart of the encrypt-side padder.

---
 rtl/block_unpad_words.sv | 164 ++++++++++++++++
 tb/tb_block_unpad_words.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/block_unpad_words.sv
`default_nettype none
// ============================================================================
// Module   : block_unpad_words
// Purpose  : Decrypt-side output adapter. Takes 128-bit plaintext blocks,
//            emits 32-bit words with byte-keep and last markers, and strips
//            PKCS#7 padding from the final block of a message.
// Config   : UNPAD_CHECK_EN - when defined, every trailing pad byte must
//            equal the pad value n. Otherwise only 1 <= n <= 16 is checked.
// Revision : 1.0 - initial release
// ============================================================================
module block_unpad_words (
    input  logic         clk,
    input  logic         rst,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic [127:0] block,
    input  logic         block_last,
    output logic         word_valid,
    input  logic         word_ready,
    output logic [31:0]  word,
    output logic [3:0]   word_keep,
    output logic         word_last,
    output logic         pad_err,
    output logic         empty
);

    localparam logic [1:0] c_IDX_LAST = 2'd3;
    localparam logic [3:0] c_KEEP_ALL = 4'b1111;

    // Holding register
    logic [127:0] r_block;
    logic [1:0]   r_idx;
    logic [1:0]   r_nwords_m1;
    logic         r_last_flag;
    logic [3:0]   r_last_keep;
    logic         r_word_valid;
    logic         r_pad_err;

    // Pad decode of the incoming block
    logic [7:0]   w_pad_n;
    logic         w_range_ok;
    logic         w_tail_ok;
    logic         w_pad_ok;
    logic [1:0]   w_payload_lo;

    // Values loaded into the holding register on accept
    logic [1:0]   w_load_nwords_m1;
    logic [3:0]   w_load_last_keep;
    logic         w_load_last_flag;
    logic         w_pad_bad;

    logic         w_final;
    logic         w_accept;
    logic         w_handshake;

    assign w_pad_n    = block[7:0];
    assign w_range_ok = (w_pad_n != 8'd0) && (w_pad_n <= 8'd16);
    assign w_pad_ok   = w_range_ok & w_tail_ok;
    // p = 16 - n, so p mod 4 is simply (-n) mod 4.
    assign w_payload_lo = 2'd0 - w_pad_n[1:0];

    // Tail check: trailing n bytes must all equal n (only when enabled)
    always_comb begin
        w_tail_ok = 1'b1;
`ifdef UNPAD_CHECK_EN
        for (int i = 0; i < 16; i++) begin
            if (8'(i) < w_pad_n && block[8*i +: 8] != w_pad_n) begin
                w_tail_ok = 1'b0;
            end
        end
`endif
    end

    // Accept-time word count, final keep and last marker for the block
    always_comb begin
        w_load_nwords_m1 = c_IDX_LAST;
        w_load_last_keep = c_KEEP_ALL;
        w_load_last_flag = block_last;
        w_pad_bad        = 1'b0;
        if (block_last) begin
            if (w_pad_ok) begin
                if (w_pad_n == 8'd16) begin
                    // Zero-byte payload: one empty terminating word.
                    w_load_nwords_m1 = 2'd0;
                    w_load_last_keep = 4'b0000;
                end else begin
                    // nwords - 1 = (p - 1) / 4 = (15 - n) / 4 for n in 1..15.
                    w_load_nwords_m1 = ~w_pad_n[3:2];
                    case (w_payload_lo)
                        2'd1:    w_load_last_keep = 4'b1000;
                        2'd2:    w_load_last_keep = 4'b1100;
                        2'd3:    w_load_last_keep = 4'b1110;
                        default: w_load_last_keep = c_KEEP_ALL;
                    endcase
                end
            end else begin
                // Bad padding: pass the whole block through untouched.
                w_pad_bad = 1'b1;
            end
        end
    end

    assign w_final     = (r_idx == r_nwords_m1);
    assign block_ready = !r_word_valid | (r_word_valid & word_ready & w_final);
    assign w_accept    = block_valid & block_ready;
    assign w_handshake = r_word_valid & word_ready;

    // Control state: word pointer, valid flag and sticky pad error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= 2'd0;
            r_word_valid <= 1'b0;
            r_pad_err    <= 1'b0;
            r_last_flag  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx        <= 2'd0;
                r_word_valid <= 1'b1;
                r_last_flag  <= w_load_last_flag;
                if (w_pad_bad) begin
                    r_pad_err <= 1'b1;
                end
            end else if (w_handshake) begin
                if (w_final) begin
                    r_word_valid <= 1'b0;
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

    // Block data and framing; left untouched by reset since never emitted then
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_block     <= block;
            r_nwords_m1 <= w_load_nwords_m1;
            r_last_keep <= w_load_last_keep;
        end
    end

    // Output word selection, forced to zero while nothing is held
    always_comb begin
        word      = 32'd0;
        word_keep = 4'b0000;
        word_last = 1'b0;
        if (r_word_valid) begin
            case (r_idx)
                2'd0:    word = r_block[127:96];
                2'd1:    word = r_block[95:64];
                2'd2:    word = r_block[63:32];
                default: word = r_block[31:0];
            endcase
            word_keep = w_final ? r_last_keep : c_KEEP_ALL;
            word_last = w_final & r_last_flag;
        end
    end

    assign word_valid = r_word_valid;
    assign empty      = !r_word_valid;
    assign pad_err    = r_pad_err;

endmodule
`default_nettype wire

// File: tb/tb_block_unpad_words.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_unpad_words
// Purpose  : Directed self-checking bench for block_unpad_words.
//            Expected results differ when UNPAD_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_unpad_words;

    logic         clk;
    logic         rst;
    logic         block_valid;
    logic         block_ready;
    logic [127:0] block;
    logic         block_last;
    logic         word_valid;
    logic         word_ready;
    logic [31:0]  word;
    logic [3:0]   word_keep;
    logic         word_last;
    logic         pad_err;
    logic         empty;

    int n_checks = 0;
    int n_pass   = 0;

    block_unpad_words dut (
        .clk         (clk),
        .rst         (rst),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block       (block),
        .block_last  (block_last),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word        (word),
        .word_keep   (word_keep),
        .word_last   (word_last),
        .pad_err     (pad_err),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; everything is driven and sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one block from idle and drain it with word_ready held high
    task automatic run_msg(input string tag, input logic [127:0] blk, input logic lst,
                           input int exp_n, input logic [3:0] fkeep, input logic flast);
        block_valid = 1'b1;
        block       = blk;
        block_last  = lst;
        word_ready  = 1'b1;
        #1;
        check({tag, " ready"}, 32'(block_ready), 32'd1);
        tick();
        block_valid = 1'b0;
        block_last  = 1'b0;
        for (int i = 0; i < exp_n; i++) begin
            check({tag, " valid"}, 32'(word_valid), 32'd1);
            check({tag, " word"}, word, blk[127-32*i -: 32]);
            check({tag, " keep"}, 32'(word_keep), (i == exp_n - 1) ? 32'(fkeep) : 32'hF);
            check({tag, " last"}, 32'(word_last), (i == exp_n - 1) ? 32'(flast) : 32'd0);
            tick();
        end
        check({tag, " drained"}, 32'(word_valid), 32'd0);
    endtask

    logic [127:0] blk_a, blk_b, blk_c, blk_d, blk_t;

    initial begin
        blk_a = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        blk_b = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
        blk_c = 128'h11223344_55667788_99AABBCC_DDEEFF00;
        blk_d = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;

        rst         = 1'b1;
        block_valid = 1'b0;
        block       = 128'd0;
        block_last  = 1'b0;
        word_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst word_valid", 32'(word_valid), 32'd0);
        check("rst word", word, 32'd0);
        check("rst keep", 32'(word_keep), 32'd0);
        check("rst last", 32'(word_last), 32'd0);
        check("rst pad_err", 32'(pad_err), 32'd0);
        check("rst empty", 32'(empty), 32'd1);
        check("rst block_ready", 32'(block_ready), 32'd1);

        // Two non-last blocks back-to-back, no bubble
        block_valid = 1'b1;
        block       = blk_a;
        block_last  = 1'b0;
        word_ready  = 1'b1;
        tick();
        block = blk_b;
        #1;
        for (int i = 0; i < 8; i++) begin
            blk_t = (i < 4) ? blk_a : blk_b;
            check("b2b valid", 32'(word_valid), 32'd1);
            check("b2b word", word, blk_t[127-32*(i%4) -: 32]);
            check("b2b keep", 32'(word_keep), 32'hF);
            check("b2b last", 32'(word_last), 32'd0);
            check("b2b block_ready", 32'(block_ready), (i == 3 || i == 7) ? 32'd1 : 32'd0);
            tick();
            if (i == 3) block_valid = 1'b0;
        end
        check("b2b idle valid", 32'(word_valid), 32'd0);
        check("b2b idle empty", 32'(empty), 32'd1);

        // n = 5, valid pad: 11 payload bytes in 3 words
        run_msg("pad5", 128'h00112233_44556677_8899AA05_05050505, 1'b1, 3, 4'b1110, 1'b1);
        check("pad5 pad_err", 32'(pad_err), 32'd0);

        // n = 16: empty payload, single terminating word
        run_msg("pad16", {16{8'h10}}, 1'b1, 1, 4'b0000, 1'b1);
        check("pad16 pad_err", 32'(pad_err), 32'd0);

        // n = 4: 12 payload bytes, final word fully kept
        run_msg("pad4", 128'h11111111_22222222_33333333_04040404, 1'b1, 3, 4'b1111, 1'b1);

        // n = 3 with a corrupted pad byte 13
`ifdef UNPAD_CHECK_EN
        run_msg("badtail", 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0070303, 1'b1, 4, 4'b1111, 1'b1);
        check("badtail pad_err", 32'(pad_err), 32'd1);
`else
        run_msg("badtail", 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0070303, 1'b1, 4, 4'b1000, 1'b1);
        check("badtail pad_err", 32'(pad_err), 32'd0);
`endif

        // n = 0: out of range in every build
        run_msg("pad0", 128'h01234567_89ABCDEF_FEDCBA98_76543200, 1'b1, 4, 4'b1111, 1'b1);
        check("pad0 pad_err", 32'(pad_err), 32'd1);

        // word_ready toggling: words held while stalled, next block on 4th handshake
        block_valid = 1'b1;
        block       = blk_c;
        block_last  = 1'b0;
        word_ready  = 1'b0;
        tick();
        block = blk_d;
        for (int w = 0; w < 4; w++) begin
            word_ready = 1'b0;
            #1;
            check("stall word", word, blk_c[127-32*w -: 32]);
            check("stall block_ready", 32'(block_ready), 32'd0);
            tick();
            check("held word", word, blk_c[127-32*w -: 32]);
            check("held keep", 32'(word_keep), 32'hF);
            word_ready = 1'b1;
            #1;
            check("hs block_ready", 32'(block_ready), (w == 3) ? 32'd1 : 32'd0);
            tick();
            if (w == 3) block_valid = 1'b0;
        end
        check("stall pad_err sticky", 32'(pad_err), 32'd1);

        // Reset mid-block after two words of blk_d
        check("mid word0", word, blk_d[127:96]);
        tick();
        check("mid word1", word, blk_d[95:64]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mrst word_valid", 32'(word_valid), 32'd0);
        check("mrst empty", 32'(empty), 32'd1);
        check("mrst pad_err", 32'(pad_err), 32'd0);
        check("mrst block_ready", 32'(block_ready), 32'd1);
        check("mrst word", word, 32'd0);

        // Next block restarts at idx 0; n = 1 leaves 15 payload bytes
        run_msg("pad1", 128'hCAFEBABE_DEADBEEF_01234567_89ABCD01, 1'b1, 4, 4'b1110, 1'b1);
        check("pad1 pad_err", 32'(pad_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
